// File: rtl/breakout_pkg.sv
// Shared definitions for the Breakout game sequencer: round states, the
// default launch key code, BCD score width and a BCD magnitude compare.
// The hiscore logic in breakout_ctrl is only built with BREAKOUT_HISCORE_EN.
package breakout_pkg;

    // Round states; encodings are shared with the top level.
    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_e;

    localparam logic [4:0] START_KEY_DEFAULT = 5'h11;
    localparam int         BCD_W             = 16;
    localparam int         BCD_DIGITS        = BCD_W / 4;

    // True when BCD value a is strictly greater than BCD value b.
    // The most significant differing digit decides.
    function automatic logic bcd_gt(input logic [BCD_W-1:0] a,
                                    input logic [BCD_W-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                gt      = (a[i*4 +: 4] > b[i*4 +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/breakout_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, increment enable and an
// optional hold at 9999. Digit 0 is count[3:0].
module bcd_counter4
    import breakout_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    input  logic             sat_en,
    output logic [BCD_W-1:0] count
);

    logic [BCD_W-1:0] count_q;
    logic [BCD_W-1:0] count_d;
    logic             carry;

    // Next count: ripple a decimal carry from digit 0 upward; clear wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        carry   = inc;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (count_q[i*4 +: 4] == 4'd9) begin
                    count_d[i*4 +: 4] = 4'd0;
                end else begin
                    count_d[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        // A carry out of the top digit means the count was 9999.
        if (sat_en && carry) begin
            count_d = count_q;
        end
        if (clr) begin
            count_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/breakout_ctrl.sv
// Breakout round sequencer: newgame / play / newball / over FSM, pause timer,
// lives register, launch-key edge detect and BCD score.
// Optional feature macro: BREAKOUT_HISCORE_EN (keeps the best final score).
module breakout_ctrl
    import breakout_pkg::*;
#(
    parameter int         LIVES        = 3,
    parameter int         DELAY_CYCLES = 100_000_000,
    parameter logic [4:0] START_KEY    = START_KEY_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        keyReady,
    input  logic [4:0]  keyCode,
    input  logic        hit,
    input  logic        miss,
    output logic        gra_still,
    output logic [1:0]  state,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic [15:0] hiscore,
    output logic        timer_busy
);

    localparam int                 TIMER_W    = $clog2(DELAY_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DELAY_CYCLES - 1);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

    state_e             state_q, state_d;
    logic               gra_still_q, gra_still_d;
    logic [2:0]         lives_q, lives_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timer_busy_q, timer_busy_d;
    logic               keyReady_q;
    logic               key_ev;
    logic               timer_load;
    logic               score_clr;
    logic               score_inc;

    // A launch is a rising keyReady carrying the start code.
    assign key_ev = keyReady & ~keyReady_q & (keyCode == START_KEY);

    // Next-state, lives, timer and score controls for the round FSM.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        timer_load = 1'b0;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        timer_d    = (timer_q != '0) ? timer_q - 1'b1 : timer_q;

        case (state_q)
            NEWGAME: begin
                if (key_ev) begin
                    state_d   = PLAY;
                    lives_d   = LIVES_INIT - 3'd1;
                    score_clr = 1'b1;
                end
            end
            PLAY: begin
                // A miss in the same cycle as a hit takes priority.
                if (miss) begin
                    timer_load = 1'b1;
                    if (lives_q == 3'd0) begin
                        state_d = OVER;
                    end else begin
                        state_d = NEWBALL;
                        lives_d = lives_q - 3'd1;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            NEWBALL: begin
                // Keys during the pause are dropped, not remembered.
                if ((timer_q == '0) && key_ev) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (timer_q == '0) begin
                    state_d = NEWGAME;
                end
            end
            default: state_d = NEWGAME;
        endcase

        if (timer_load) begin
            timer_d = TIMER_LOAD;
        end

        gra_still_d  = (state_d != PLAY);
        // Rises with the pause entry and falls on the edge where the
        // counter's final zero cycle ends, so it covers the whole pause.
        timer_busy_d = timer_load | (timer_q != '0);
    end

    // Round state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= NEWGAME;
            gra_still_q  <= 1'b1;
            lives_q      <= LIVES_INIT;
            timer_q      <= '0;
            timer_busy_q <= 1'b0;
            keyReady_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gra_still_q  <= gra_still_d;
            lives_q      <= lives_d;
            timer_q      <= timer_d;
            timer_busy_q <= timer_busy_d;
            keyReady_q   <= keyReady;
        end
    end

    bcd_counter4 u_score (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (score_clr),
        .inc    (score_inc),
        .sat_en (1'b1),
        .count  (score)
    );

`ifdef BREAKOUT_HISCORE_EN
    logic [BCD_W-1:0] hiscore_q, hiscore_d;

    // Capture the final score of a game when it beats the best so far.
    always_comb begin
        hiscore_d = hiscore_q;
        if ((state_q == PLAY) && (state_d == OVER) && bcd_gt(score, hiscore_q)) begin
            hiscore_d = score;
        end
    end

    // Best score survives new games; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hiscore_q <= '0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = '0;
`endif

    assign state      = state_q;
    assign gra_still  = gra_still_q;
    assign lives      = lives_q;
    assign timer_busy = timer_busy_q;

endmodule

// File: tb/tb_breakout_ctrl.sv
// Self-checking bench for breakout_ctrl with LIVES=3, DELAY_CYCLES=16,
// START_KEY=5'h11. Expected hiscore follows BREAKOUT_HISCORE_EN.
module tb_breakout_ctrl;

    logic        clk;
    logic        rstn;
    logic        keyReady;
    logic [4:0]  keyCode;
    logic        hit;
    logic        miss;
    logic        gra_still;
    logic [1:0]  state;
    logic [2:0]  lives;
    logic [15:0] score;
    logic [15:0] hiscore;
    logic        timer_busy;

    int checks   = 0;
    int failures = 0;

`ifdef BREAKOUT_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    typedef struct {
        logic        rstn;
        logic        kr;
        logic [4:0]  kc;
        logic        hit;
        logic        miss;
        logic [1:0]  st;
        logic        gra;
        logic [2:0]  lv;
        logic [15:0] sc;
        logic        busy;
    } vec_t;

    vec_t vecs[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    breakout_ctrl #(
        .LIVES        (3),
        .DELAY_CYCLES (16),
        .START_KEY    (5'h11)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .keyReady   (keyReady),
        .keyCode    (keyCode),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .state      (state),
        .lives      (lives),
        .score      (score),
        .hiscore    (hiscore),
        .timer_busy (timer_busy)
    );

    function automatic vec_t mk(logic r, logic kr, logic [4:0] kc, logic h, logic m,
                                logic [1:0] st, logic g, logic [2:0] lv,
                                logic [15:0] sc, logic b);
        vec_t v;
        v.rstn = r;  v.kr = kr; v.kc = kc; v.hit = h; v.miss = m;
        v.st = st;   v.gra = g; v.lv = lv; v.sc = sc; v.busy = b;
        return v;
    endfunction

    function automatic logic [15:0] hs_exp(input logic [15:0] v);
        return HS_EN ? v : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic g,
                              input logic [2:0] lv, input logic [15:0] sc, input logic b);
        check({tag, ".state"},      {14'd0, state},      {14'd0, st});
        check({tag, ".gra_still"},  {15'd0, gra_still},  {15'd0, g});
        check({tag, ".lives"},      {13'd0, lives},      {13'd0, lv});
        check({tag, ".score"},      score,               sc);
        check({tag, ".timer_busy"}, {15'd0, timer_busy}, {15'd0, b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        keyReady = 1'b1;
        keyCode  = 5'h11;
        tick();
        keyReady = 1'b0;
        tick();
    endtask

    // One full game from newgame: n hits, then three misses with relaunches.
    task automatic play_game(input string tag, input int n_hits);
        press();
        hit = 1'b1;
        repeat (n_hits) tick();
        hit = 1'b0;
        for (int m = 0; m < 3; m++) begin
            miss = 1'b1;
            tick();
            miss = 1'b0;
            if (m < 2) begin
                repeat (16) tick();
                press();
            end
        end
        check({tag, ".over_state"}, {14'd0, state}, 16'd3);
        repeat (17) tick();
        check({tag, ".end_state"}, {14'd0, state}, 16'd0);
    endtask

    initial begin
        int busy_cnt;

        rstn     = 1'b0;
        keyReady = 1'b0;
        keyCode  = 5'h00;
        hit      = 1'b0;
        miss     = 1'b0;

        // Reset, start, wrong key, hits, key ignored in play.
        vecs[0]  = mk(0, 0, 5'h00, 0, 0, 2'b00, 1, 3'd3, 16'h0000, 0);
        vecs[1]  = mk(0, 0, 5'h00, 0, 0, 2'b00, 1, 3'd3, 16'h0000, 0);
        vecs[2]  = mk(1, 0, 5'h00, 0, 0, 2'b00, 1, 3'd3, 16'h0000, 0);
        vecs[3]  = mk(1, 1, 5'h0C, 0, 0, 2'b00, 1, 3'd3, 16'h0000, 0);
        vecs[4]  = mk(1, 0, 5'h0C, 0, 0, 2'b00, 1, 3'd3, 16'h0000, 0);
        vecs[5]  = mk(1, 1, 5'h11, 0, 0, 2'b01, 0, 3'd2, 16'h0000, 0);
        vecs[6]  = mk(1, 1, 5'h11, 0, 0, 2'b01, 0, 3'd2, 16'h0000, 0);
        vecs[7]  = mk(1, 0, 5'h11, 1, 0, 2'b01, 0, 3'd2, 16'h0001, 0);
        vecs[8]  = mk(1, 0, 5'h11, 1, 0, 2'b01, 0, 3'd2, 16'h0002, 0);
        vecs[9]  = mk(1, 0, 5'h11, 0, 0, 2'b01, 0, 3'd2, 16'h0002, 0);
        vecs[10] = mk(1, 1, 5'h11, 0, 0, 2'b01, 0, 3'd2, 16'h0002, 0);
        vecs[11] = mk(1, 0, 5'h11, 0, 0, 2'b01, 0, 3'd2, 16'h0002, 0);

        for (int i = 0; i < 12; i++) begin
            rstn     = vecs[i].rstn;
            keyReady = vecs[i].kr;
            keyCode  = vecs[i].kc;
            hit      = vecs[i].hit;
            miss     = vecs[i].miss;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].gra, vecs[i].lv,
                       vecs[i].sc, vecs[i].busy);
            check($sformatf("vec%0d.hiscore", i), hiscore, 16'h0000);
        end
        keyReady = 1'b0;
        hit      = 1'b0;

        // Ten more hits: 2 -> 12 with a decimal carry.
        hit = 1'b1;
        repeat (10) tick();
        hit = 1'b0;
        tick();
        check("score_0012", score, 16'h0012);

        // Hit and miss together: miss wins, score unchanged.
        hit  = 1'b1;
        miss = 1'b1;
        tick();
        hit  = 1'b0;
        miss = 1'b0;
        check_outs("hit_miss", 2'b10, 1, 3'd1, 16'h0012, 1);

        // Newball pause: early key dropped, key at cycle 16 accepted,
        // hit during the pause ignored.
        busy_cnt = 0;
        for (int k = 0; k <= 17; k++) begin
            if (timer_busy) busy_cnt++;
            if (k == 6) begin
                check("early_key.state", {14'd0, state}, 16'd2);
            end
            if (k == 16) begin
                check("pause_end.state", {14'd0, state}, 16'd2);
                check("pause_end.busy", {15'd0, timer_busy}, 16'd0);
            end
            if (k == 17) begin
                check_outs("relaunch", 2'b01, 0, 3'd1, 16'h0012, 0);
            end
            keyReady = (k == 5) || (k == 16);
            keyCode  = 5'h11;
            hit      = (k == 8);
            if (k < 17) tick();
        end
        keyReady = 1'b0;
        hit      = 1'b0;
        check("busy_cycles", 16'(busy_cnt), 16'd16);

        // Run the score up to 9998, then saturate at 9999.
        hit = 1'b1;
        repeat (9986) tick();
        hit = 1'b0;
        check("score_9998", score, 16'h9998);
        hit = 1'b1;
        repeat (3) tick();
        hit = 1'b0;
        check("score_9999", score, 16'h9999);

        // Game over: miss to newball, relaunch, final miss.
        miss = 1'b1;
        tick();
        miss = 1'b0;
        check_outs("miss2", 2'b10, 1, 3'd0, 16'h9999, 1);
        repeat (16) tick();
        press();
        check("relaunch2.state", {14'd0, state}, 16'd1);
        miss = 1'b1;
        tick();
        miss = 1'b0;
        check_outs("over", 2'b11, 1, 3'd0, 16'h9999, 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check("over_hold.state", {14'd0, state}, 16'd3);
            if (k == 16) check_outs("over_exit", 2'b00, 1, 3'd0, 16'h9999, 0);
        end
        check("hiscore_9999", hiscore, hs_exp(16'h9999));

        // New start clears score and reloads lives.
        keyReady = 1'b1;
        keyCode  = 5'h11;
        tick();
        keyReady = 1'b0;
        check_outs("restart", 2'b01, 0, 3'd2, 16'h0000, 0);

        // Reset mid-game while the pause timer holds 7.
        hit = 1'b1;
        repeat (5) tick();
        hit  = 1'b0;
        miss = 1'b1;
        tick();
        miss = 1'b0;
        check("pre_reset.score", score, 16'h0005);
        repeat (8) tick();
        rstn = 1'b0;
        tick();
        check_outs("mid_reset", 2'b00, 1, 3'd3, 16'h0000, 0);
        check("mid_reset.hiscore", hiscore, 16'h0000);
        rstn = 1'b1;
        tick();

        // Hiscore keeps the better of two games.
        play_game("game42", 42);
        check("game42.score", score, 16'h0042);
        check("game42.hiscore", hiscore, hs_exp(16'h0042));
        play_game("game17", 17);
        check("game17.score", score, 16'h0017);
        check("game17.hiscore", hiscore, hs_exp(16'h0042));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
